// File: rtl/temporizador_juego_pkg.sv
// Shared definitions for the game timer, control FSM and display driver:
// state encodings, digit widths and constant BCD split helpers.
package temporizador_juego_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } estado_t;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned SEG_W       = 7;

    // Elaboration-time only: used to build reset/load constants.
    function automatic logic [BCD_DIGIT_W-1:0] bcd_decenas(input int unsigned valor);
        return BCD_DIGIT_W'(valor / 10);
    endfunction

    function automatic logic [BCD_DIGIT_W-1:0] bcd_unidades(input int unsigned valor);
        return BCD_DIGIT_W'(valor % 10);
    endfunction

endpackage

// File: rtl/contador_bcd_desc.sv
// Two-digit BCD down-counter with parallel load and a zero flag.
// Decrementing at 00 is ignored, so the count never wraps.
module contador_bcd_desc
    import temporizador_juego_pkg::*;
#(
    parameter logic [BCD_DIGIT_W-1:0] RST_DECENAS  = '0,
    parameter logic [BCD_DIGIT_W-1:0] RST_UNIDADES = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cargar_i,
    input  logic [BCD_DIGIT_W-1:0] carga_decenas_i,
    input  logic [BCD_DIGIT_W-1:0] carga_unidades_i,
    input  logic                   dec_i,
    output logic [BCD_DIGIT_W-1:0] decenas_o,
    output logic [BCD_DIGIT_W-1:0] unidades_o,
    output logic                   cero_o
);

    logic [BCD_DIGIT_W-1:0] decenas_q;
    logic [BCD_DIGIT_W-1:0] unidades_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            decenas_q  <= RST_DECENAS;
            unidades_q <= RST_UNIDADES;
        end else if (cargar_i) begin
            decenas_q  <= carga_decenas_i;
            unidades_q <= carga_unidades_i;
        end else if (dec_i && !cero_o) begin
            if (unidades_q == '0) begin
                unidades_q <= BCD_DIGIT_W'(9);
                decenas_q  <= decenas_q - BCD_DIGIT_W'(1);
            end else begin
                unidades_q <= unidades_q - BCD_DIGIT_W'(1);
            end
        end
    end

    assign cero_o     = (decenas_q == '0) && (unidades_q == '0);
    assign decenas_o  = decenas_q;
    assign unidades_o = unidades_q;

endmodule

// File: rtl/temporizador_juego.sv
// Game-duration timer: armed by a start pulse, counts GAME_SECONDS down at one
// step per TICKS_PER_SEC cycles and pulses finalizado_o when it reaches zero.
module temporizador_juego
    import temporizador_juego_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned GAME_SECONDS  = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iniciar_i,
    input  logic                   pausa_i,
    output logic                   en_curso_o,
    output logic                   tick_segundo_o,
    output logic                   finalizado_o,
    output logic [SEG_W-1:0]       segundos_restantes_o,
    output logic [BCD_DIGIT_W-1:0] decenas_o,
    output logic [BCD_DIGIT_W-1:0] unidades_o
);

    localparam int unsigned          PRESC_W      = $clog2(TICKS_PER_SEC);
    localparam logic [PRESC_W-1:0]   PRESC_ULTIMO = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [SEG_W-1:0]     SEG_INICIO   = SEG_W'(GAME_SECONDS);
    localparam logic [BCD_DIGIT_W-1:0] DEC_INICIO = bcd_decenas(GAME_SECONDS);
    localparam logic [BCD_DIGIT_W-1:0] UNI_INICIO = bcd_unidades(GAME_SECONDS);

    if (GAME_SECONDS < 1 || GAME_SECONDS > 99 ||
        TICKS_PER_SEC < 2 || TICKS_PER_SEC > 2**27) begin : g_param_err
        $error("temporizador_juego: parameter out of range");
    end

    estado_t            estado_q;
    logic [PRESC_W-1:0] presc_q;
    logic [SEG_W-1:0]   segundos_q;
    logic               tick_q;

    logic cargar;
    logic decrementar;
    logic bcd_cero;

    // A start pulse wins over pause and over a coincident terminal tick.
    always_comb begin
        cargar      = iniciar_i && ((estado_q == ST_IDLE) || (estado_q == ST_RUN));
        decrementar = (estado_q == ST_RUN) && !iniciar_i && !pausa_i &&
                      (presc_q == PRESC_ULTIMO) && !bcd_cero;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= ST_IDLE;
            presc_q    <= '0;
            segundos_q <= SEG_INICIO;
            tick_q     <= 1'b0;
        end else begin
            tick_q <= decrementar;
            case (estado_q)
                ST_IDLE: begin
                    if (cargar) begin
                        estado_q   <= ST_RUN;
                        presc_q    <= '0;
                        segundos_q <= SEG_INICIO;
                    end
                end
                ST_RUN: begin
                    if (cargar) begin
                        presc_q    <= '0;
                        segundos_q <= SEG_INICIO;
                    end else if (!pausa_i) begin
                        if (presc_q == PRESC_ULTIMO) begin
                            presc_q <= '0;
                            if (decrementar) begin
                                segundos_q <= segundos_q - SEG_W'(1);
                                if (segundos_q == SEG_W'(1)) begin
                                    estado_q <= ST_DONE;
                                end
                            end
                        end else begin
                            presc_q <= presc_q + PRESC_W'(1);
                        end
                    end
                end
                ST_DONE: estado_q <= ST_IDLE;
                default: estado_q <= ST_IDLE;
            endcase
        end
    end

    contador_bcd_desc #(
        .RST_DECENAS  (DEC_INICIO),
        .RST_UNIDADES (UNI_INICIO)
    ) u_contador_bcd (
        .clk              (clk),
        .reset            (reset),
        .cargar_i         (cargar),
        .carga_decenas_i  (DEC_INICIO),
        .carga_unidades_i (UNI_INICIO),
        .dec_i            (decrementar),
        .decenas_o        (decenas_o),
        .unidades_o       (unidades_o),
        .cero_o           (bcd_cero)
    );

    assign en_curso_o           = (estado_q == ST_RUN);
    assign finalizado_o         = (estado_q == ST_DONE);
    assign tick_segundo_o       = tick_q;
    assign segundos_restantes_o = segundos_q;

endmodule

// File: tb/tb_temporizador_juego.sv
// Directed bench for the game timer: a 4-tick/3-second instance for most
// scenarios and a 2-tick/12-second instance for the BCD borrow sequence.
module tb_temporizador_juego;

    logic       clk;
    logic       reset;
    logic       ini_a, pau_a, ini_b, pau_b;
    logic       en_a, tk_a, fin_a, en_b, tk_b, fin_b;
    logic [6:0] seg_a, seg_b;
    logic [3:0] dec_a, uni_a, dec_b, uni_b;

    int n_assert;
    int n_fail;

    temporizador_juego #(
        .TICKS_PER_SEC (4),
        .GAME_SECONDS  (3)
    ) dut_a (
        .clk                  (clk),
        .reset                (reset),
        .iniciar_i            (ini_a),
        .pausa_i              (pau_a),
        .en_curso_o           (en_a),
        .tick_segundo_o       (tk_a),
        .finalizado_o         (fin_a),
        .segundos_restantes_o (seg_a),
        .decenas_o            (dec_a),
        .unidades_o           (uni_a)
    );

    temporizador_juego #(
        .TICKS_PER_SEC (2),
        .GAME_SECONDS  (12)
    ) dut_b (
        .clk                  (clk),
        .reset                (reset),
        .iniciar_i            (ini_b),
        .pausa_i              (pau_b),
        .en_curso_o           (en_b),
        .tick_segundo_o       (tk_b),
        .finalizado_o         (fin_b),
        .segundos_restantes_o (seg_b),
        .decenas_o            (dec_b),
        .unidades_o           (uni_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int c, input bit en, input bit fin,
                         input bit tk, input int seg);
        string t;
        t = $sformatf("%s c%0d", tag, c);
        chk({t, " en_curso"}, 32'(en_a), 32'(en));
        chk({t, " finalizado"}, 32'(fin_a), 32'(fin));
        chk({t, " tick"}, 32'(tk_a), 32'(tk));
        chk({t, " segundos"}, 32'(seg_a), 32'(seg));
        chk({t, " decenas"}, 32'(dec_a), 32'(seg / 10));
        chk({t, " unidades"}, 32'(uni_a), 32'(seg % 10));
    endtask

    // Start at cycle 0 (with pausa high, which IDLE must ignore), run to IDLE.
    task automatic run_full(input string tag);
        ini_a = 1'b1;
        pau_a = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            ini_a = 1'b0;
            pau_a = 1'b0;
            chk_a(tag, c, (c >= 1 && c <= 12), (c == 13), (c == 5 || c == 9 || c == 13),
                  (c < 5) ? 3 : (c < 9) ? 2 : (c < 13) ? 1 : 0);
        end
    endtask

    initial begin
        int n_fin;
        int seg;
        n_assert = 0;
        n_fail   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        ini_a = 1'b0;
        pau_a = 1'b0;
        ini_b = 1'b0;
        pau_b = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state and quiet idle
        for (int c = 0; c < 20; c++) begin
            step();
            chk_a("idle", c, 1'b0, 1'b0, 1'b0, 3);
        end

        // Plain run
        run_full("run");

        // Pause for cycles 3..12 shifts everything by 10
        ini_a = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            step();
            ini_a = 1'b0;
            pau_a = (c >= 3 && c <= 12);
            chk_a("pause", c, (c >= 1 && c <= 22), (c == 23),
                  (c == 15 || c == 19 || c == 23),
                  (c < 15) ? 3 : (c < 19) ? 2 : (c < 23) ? 1 : 0);
        end
        pau_a = 1'b0;
        step();

        // Restart at cycle 8 while count is 2; aborted run never finishes
        ini_a = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            step();
            ini_a = (c == 8);
            chk_a("restart", c, (c >= 1 && c <= 20), (c == 21),
                  (c == 5 || c == 13 || c == 17 || c == 21),
                  (c < 5) ? 3 : (c < 9) ? 2 : (c < 13) ? 3 : (c < 17) ? 2 : (c < 21) ? 1 : 0);
        end
        ini_a = 1'b0;
        step();

        // Reset asserted at cycle 10 aborts the run silently
        ini_a = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            ini_a = 1'b0;
            reset = (c == 10);
            if (c <= 10) begin
                chk_a("rst_mid", c, 1'b1, 1'b0, (c == 5 || c == 9),
                      (c < 5) ? 3 : (c < 9) ? 2 : 1);
            end else begin
                chk_a("rst_mid", c, 1'b0, 1'b0, 1'b0, 3);
            end
        end
        reset = 1'b0;
        run_full("after_rst");

        // 12-second instance: BCD borrow sequence, ticks every 2 cycles
        n_fin = 0;
        ini_b = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            ini_b = 1'b0;
            seg = (c < 3) ? 12 : (c >= 25) ? 0 : 12 - (c - 1) / 2;
            if (fin_b) n_fin++;
            chk($sformatf("bcd c%0d en_curso", c), 32'(en_b), 32'(c <= 24));
            chk($sformatf("bcd c%0d finalizado", c), 32'(fin_b), 32'(c == 25));
            chk($sformatf("bcd c%0d tick", c), 32'(tk_b),
                32'(c >= 3 && c <= 25 && (c % 2 == 1)));
            chk($sformatf("bcd c%0d segundos", c), 32'(seg_b), 32'(seg));
            chk($sformatf("bcd c%0d decenas", c), 32'(dec_b), 32'(seg / 10));
            chk($sformatf("bcd c%0d unidades", c), 32'(uni_b), 32'(seg % 10));
        end
        chk("bcd finalizado_count", 32'(n_fin), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
